vga_tx: RTL and testbench
=========================

# vga_tx

Frame-buffer reader and VGA transmitter. It is the display-side counterpart of the capture path, which writes 8-bit greyscale pixels into the shared dual-port BRAM. This block generates 640x480@60 VGA timing on its own pixel clock and reads the stored image back out of the BRAM's read port. It drives sync, data-enable and greyscale video to the DAC/pins, placing the image in a fixed window with black borders.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, HS pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, VS pulse width
- V_BP, 33, vertical back porch
- IMG_W, 128, stored image width (pixels)
- IMG_H, 128, stored image height (lines); IMG_W*IMG_H ≤ 16384
- X0, 64, first window column
- Y0, 48, first window line

Ports:
- V_CLK  in  1  pixel clock, 25.175 MHz; all logic on rising edge
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- ENABLE  in  1  run; low holds timing at origin and blanks output
- BRAM_ADDR  out  14  read address (registered)
- BRAM_RE  out  1  read enable (registered)
- BRAM_DOUT  in  8  read data; valid 1 cycle after address/RE
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_DE  out  1  visible-area flag
- VGA_VIDEO  out  8  greyscale pixel
- FRAME_START  out  1  one-cycle pulse aligned with first output pixel of frame

## Operation
- Counters:
  - H counts 0..H_TOT-1 with H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800.
  - V counts 0..V_TOT-1 (525) and advances when H wraps.
  - V wraps to 0 after V_TOT-1.
- Stage-0 decode from (H,V):
  - vis = H<H_VIS && V<V_VIS
  - hs = !(H_VIS+H_FP ≤ H < H_VIS+H_FP+H_SYNC)
  - vs = likewise on V
  - win = X0 ≤ H < X0+S*IMG_W && Y0 ≤ V < Y0+S*IMG_H, where S=1 (or 2, see Configuration)
- Address: when win, BRAM_ADDR ← ((V-Y0)/S)*IMG_W + (H-X0)/S, computed in 14 bits modulo 16384.
  - Implementation is incremental: a line-base register plus a column step, with no multiplier. It must match this formula exactly.
  - BRAM_RE ← win.
  - When !win, BRAM_RE ← 0 and BRAM_ADDR holds its value.
  - BRAM_ADDR and the line base are cleared to 0 whenever V ≥ V_VIS.
- Output stage:
  - vis, hs, vs and win are delayed 2 cycles.
  - VGA_VIDEO = win_d2 ? BRAM_DOUT : 0, forced to 0 when !vis_d2.
  - VGA_DE = vis_d2; VGA_HS = hs_d2; VGA_VS = vs_d2. All outputs are registered.
  - FRAME_START = 1 for the cycle in which the (H,V)=(0,0) pixel appears at the outputs.
- ENABLE low:
  - H and V are held at 0 and the pipeline is flushed to idle values (same as reset).
  - Output resumes from (0,0) on the first cycle ENABLE is high.
- Reset values:
  - H=V=0, BRAM_ADDR=0, BRAM_RE=0
  - VGA_HS=1, VGA_VS=1, VGA_DE=0, VGA_VIDEO=0, FRAME_START=0
- Reset mid-frame: asynchronous clear to the reset values. Timing restarts at (0,0) on the first clock edge after RST_N rises.

## Timing
- Fixed latency of 2 V_CLK from the counter value to the outputs:
  - cycle t: (H,V) is decoded;
  - t+1: BRAM_ADDR/BRAM_RE are registered;
  - t+2: BRAM_DOUT is captured into VGA_VIDEO.
- The BRAM read latency is exactly 1 cycle and is not handshaked. The read port never stalls.
- The HS pulse spans outputs for H=656..751, i.e. 96 cycles. The VS pulse spans lines 490..491.
- One line is 800 cycles; one frame is 420000 cycles.

## Configuration
- VGA_TX_SCALE2_EN:
  - Defined: S=2. Each stored pixel is replicated 2x2, giving a displayed window of 2*IMG_W x 2*IMG_H (256x256 at defaults).
  - Horizontal: the address advances every second window column.
  - Vertical: each stored line is read twice. The line base rewinds at the end of the first repetition and advances after the second.
  - Undefined: S=1, giving a 1:1 window of IMG_W x IMG_H.
- Sync timing and latency are identical in both builds.

## Test plan
- Reset check: hold RST_N=0 → all outputs at reset values. Release → FRAME_START pulses 2 cycles after the first counted edge.
- Line/frame timing: run 2 frames → VGA_HS low exactly 96 cycles per 800-cycle line. VGA_VS low for lines 490-491. VGA_DE high for 640x480 pixels per frame.
- First pixel, S=1: BRAM model returns addr[7:0] → BRAM_ADDR=0 with RE at (64,48). VGA_VIDEO=0x00 with DE 2 cycles later. Last window pixel has addr 16383 and VIDEO 0xFF. Border pixels are 0.
- Scale2 (macro defined): window line 48 addresses 0,0,1,1,…,127,127. Line 49 repeats 0..127 pairwise. Line 50 starts at 128. The window ends at H=320, V=304.
- ENABLE drop mid-line (at H=300, V=100), raise 50 cycles later → outputs idle while low. Timing restarts at (0,0), with FRAME_START 2 cycles after re-enable.
- Async reset mid-window → BRAM_RE=0 and VIDEO=0 immediately, without a clock edge. After release, the next frame's addresses start from 0.

Source files
------------

// File: rtl/vga_tx_if.sv
// vga_tx_if: BRAM read port and VGA pin bundle of the display path.
// master = vga_tx (issues reads, drives pins); slave = BRAM read port / DAC side.
interface vga_tx_if;
  logic [13:0] BRAM_ADDR;
  logic        BRAM_RE;
  logic [7:0]  BRAM_DOUT;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_DE;
  logic [7:0]  VGA_VIDEO;
  logic        FRAME_START;

  modport master (
    output BRAM_ADDR, BRAM_RE,
    input  BRAM_DOUT,
    output VGA_HS, VGA_VS, VGA_DE, VGA_VIDEO, FRAME_START
  );

  modport slave (
    input  BRAM_ADDR, BRAM_RE,
    output BRAM_DOUT,
    input  VGA_HS, VGA_VS, VGA_DE, VGA_VIDEO, FRAME_START
  );
endinterface

// File: rtl/vga_tx.sv
// vga_tx: VGA raster timing plus frame-buffer readout into a fixed window.
// Latency from raster position to pins is 2 clocks: stage 1 registers the BRAM
// read request, stage 2 is the BRAM's own output register together with the
// delayed sync/DE/window flags.
// Build option: define VGA_TX_SCALE2_EN to replicate each stored pixel 2x2.
module vga_tx #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int X0     = 64,
  parameter int Y0     = 48
) (
  input  logic     V_CLK,
  input  logic     RST_N,
  input  logic     ENABLE,
  vga_tx_if.master vif
);

`ifdef VGA_TX_SCALE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [HW-1:0] WX_BEG  = HW'(X0);
  localparam logic [HW-1:0] WX_END  = HW'(X0 + S * IMG_W);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [VW-1:0] WY_BEG  = VW'(Y0);
  localparam logic [VW-1:0] WY_END  = VW'(Y0 + S * IMG_H);
  localparam logic [13:0]   IMG_W_C = 14'(IMG_W);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic win;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, win: 1'b0, fs: 1'b0};

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  ctl_t          ctl0, ctl1, ctl2;
  logic          win_row;
  logic          col_step;
  logic          line_adv;
  logic [13:0]   line_base;
  logic [13:0]   addr_q;
  logic          re_q;

  // raster position; held at the origin while disabled
  always_ff @(posedge V_CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!ENABLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign win_row = (v_cnt >= WY_BEG) && (v_cnt < WY_END);

  // stage 0: decode flags from the current raster position
  always_comb begin
    ctl0     = CTL_IDLE;
    ctl0.vis = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    ctl0.hs  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    ctl0.vs  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    ctl0.win = win_row && (h_cnt >= WX_BEG) && (h_cnt < WX_END);
    ctl0.fs  = (h_cnt == '0) && (v_cnt == '0);
  end

`ifdef VGA_TX_SCALE2_EN
  // column address moves on even window offsets; the line base only moves
  // after the second (odd-offset) repetition of a stored line
  assign col_step = ~(h_cnt[0] ^ WX_BEG[0]);
  assign line_adv = v_cnt[0] ^ WY_BEG[0];
`else
  assign col_step = 1'b1;
  assign line_adv = 1'b1;
`endif

  // stage 1: BRAM read request built incrementally from the line base
  always_ff @(posedge V_CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q    <= '0;
      re_q      <= 1'b0;
      line_base <= '0;
      ctl1      <= CTL_IDLE;
    end else if (!ENABLE) begin
      addr_q    <= '0;
      re_q      <= 1'b0;
      line_base <= '0;
      ctl1      <= CTL_IDLE;
    end else begin
      ctl1 <= ctl0;
      re_q <= ctl0.win;
      if (v_cnt >= V_VIS_C) begin
        addr_q    <= '0;
        line_base <= '0;
      end else begin
        if (ctl0.win) begin
          if (h_cnt == WX_BEG)
            addr_q <= line_base;
          else if (col_step)
            addr_q <= addr_q + 14'd1;
        end
        if (win_row && (h_cnt == H_LAST) && line_adv)
          line_base <= line_base + IMG_W_C;
      end
    end
  end

  // stage 2: flags aligned with the BRAM output register
  always_ff @(posedge V_CLK or negedge RST_N) begin
    if (!RST_N)
      ctl2 <= CTL_IDLE;
    else if (!ENABLE)
      ctl2 <= CTL_IDLE;
    else
      ctl2 <= ctl1;
  end

  assign vif.BRAM_ADDR   = addr_q;
  assign vif.BRAM_RE     = re_q;
  assign vif.VGA_HS      = ctl2.hs;
  assign vif.VGA_VS      = ctl2.vs;
  assign vif.VGA_DE      = ctl2.vis;
  assign vif.FRAME_START = ctl2.fs;
  // BRAM data is gated by registered flags only, so an async reset blanks it at once
  assign vif.VGA_VIDEO   = (ctl2.win && ctl2.vis) ? vif.BRAM_DOUT : 8'h00;

endmodule

// File: tb/tb_vga_tx.sv
// tb_vga_tx: randomized checks of vga_tx against a position-based reference model.
// Uses a reduced raster geometry so that several whole frames fit in a short run.
module tb_vga_tx;
  localparam int H_VIS = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
  localparam int V_VIS = 24, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int IMG_W = 12, IMG_H = 8, X0 = 5, Y0 = 3;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
`ifdef VGA_TX_SCALE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam logic [11:0] VGA_IDLE = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic [7:0] dout_q = 8'h00;

  vga_tx_if vif ();

  vga_tx #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0)
  ) dut (
    .V_CLK(clk),
    .RST_N(rst_n),
    .ENABLE(enable),
    .vif(vif)
  );

  always #5 clk = ~clk;

  // BRAM read port: 1-cycle latency, content = low byte of the address
  always @(posedge clk) if (vif.BRAM_RE) dout_q <= vif.BRAM_ADDR[7:0];
  assign vif.BRAM_DOUT = dout_q;

  logic [11:0] obs_vga;
  logic [14:0] obs_bram;
  assign obs_vga  = {vif.VGA_HS, vif.VGA_VS, vif.VGA_DE, vif.VGA_VIDEO, vif.FRAME_START};
  assign obs_bram = {vif.BRAM_RE, vif.BRAM_ADDR};

  int errors = 0;
  int checks = 0;
  int n = 0;         // enabled clock edges since the raster last sat at (0,0)
  int exp_addr = 0;  // expected BRAM_ADDR (holds outside the window)

  function automatic int hpos(int p); return p % H_TOT; endfunction
  function automatic int vpos(int p); return (p / H_TOT) % V_TOT; endfunction

  function automatic bit in_win(int p);
    int h = hpos(p);
    int v = vpos(p);
    return h >= X0 && h < X0 + S * IMG_W && v >= Y0 && v < Y0 + S * IMG_H;
  endfunction

  function automatic int pix_addr(int p);
    return (((vpos(p) - Y0) / S) * IMG_W + (hpos(p) - X0) / S) % 16384;
  endfunction

  function automatic logic [11:0] exp_vga(int k);
    int p, h, v;
    logic hs, vs, de, fs;
    logic [7:0] vid;
    if (k < 2) return VGA_IDLE;
    p   = k - 2;
    h   = hpos(p);
    v   = vpos(p);
    hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
    vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
    de  = h < H_VIS && v < V_VIS;
    vid = (de && in_win(p)) ? 8'(pix_addr(p)) : 8'h00;
    fs  = (p % FRAME) == 0;
    return {hs, vs, de, vid, fs};
  endfunction

  function automatic logic [14:0] exp_bram(int k);
    if (k < 1) return 15'h0;
    return {in_win(k - 1), 14'(exp_addr)};
  endfunction

  // advance one clock and the model; returns on the following falling edge
  task automatic tick();
    @(posedge clk);
    if (!rst_n || !enable) begin
      n = 0;
      exp_addr = 0;
    end else begin
      n++;
      if (vpos(n - 1) >= V_VIS) exp_addr = 0;
      else if (in_win(n - 1)) exp_addr = pix_addr(n - 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs_vga !== VGA_IDLE) begin errors++; $display("FAIL reset_async_vga got=%h exp=%h", obs_vga, VGA_IDLE); end
    checks++; if (obs_bram !== 15'h0) begin errors++; $display("FAIL reset_async_bram got=%h exp=0", obs_bram); end
    enable = 1'b1;
    repeat (3) tick();
    checks++; if (obs_vga !== VGA_IDLE) begin errors++; $display("FAIL reset_hold_vga got=%h exp=%h", obs_vga, VGA_IDLE); end
    rst_n = 1'b1;
    tick();
    checks++; if (vif.FRAME_START !== 1'b0) begin errors++; $display("FAIL reset_fs_early got=%b exp=0", vif.FRAME_START); end
    tick();
    checks++; if (vif.FRAME_START !== 1'b1) begin errors++; $display("FAIL reset_fs_pulse got=%b exp=1", vif.FRAME_START); end
    checks++; if (obs_vga !== exp_vga(n)) begin errors++; $display("FAIL reset_first_vga n=%0d got=%h exp=%h", n, obs_vga, exp_vga(n)); end
    tick();
    checks++; if (vif.FRAME_START !== 1'b0) begin errors++; $display("FAIL reset_fs_single got=%b exp=0", vif.FRAME_START); end
  endtask

  task automatic test_frames();
    int hs_low = 0, vs_low = 0, de_cnt = 0;
    int first_pos = Y0 * H_TOT + X0;
    int last_pos  = (Y0 + S * IMG_H - 1) * H_TOT + X0 + S * IMG_W - 1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++; if (obs_vga !== exp_vga(n)) begin errors++; $display("FAIL frames_vga n=%0d got=%h exp=%h", n, obs_vga, exp_vga(n)); end
      checks++; if (obs_bram !== exp_bram(n)) begin errors++; $display("FAIL frames_bram n=%0d got=%h exp=%h", n, obs_bram, exp_bram(n)); end
      if (!vif.VGA_HS) hs_low++;
      if (!vif.VGA_VS) vs_low++;
      if (vif.VGA_DE) de_cnt++;
      if ((n - 1) % FRAME == first_pos) begin
        checks++; if (obs_bram !== {1'b1, 14'd0}) begin errors++; $display("FAIL first_addr got=%h exp=%h", obs_bram, {1'b1, 14'd0}); end
      end
      for (int k = 1; k <= 2; k++) begin
        if ((n - 1) % FRAME == (Y0 + k) * H_TOT + X0) begin
          checks++; if (vif.BRAM_ADDR !== 14'((k / S) * IMG_W)) begin errors++; $display("FAIL line%0d_start got=%0d exp=%0d", k, vif.BRAM_ADDR, (k / S) * IMG_W); end
        end
      end
      if ((n - 2) % FRAME == first_pos) begin
        checks++; if ({vif.VGA_DE, vif.VGA_VIDEO} !== 9'h100) begin errors++; $display("FAIL first_pixel got=%h exp=100", {vif.VGA_DE, vif.VGA_VIDEO}); end
      end
      if ((n - 2) % FRAME == last_pos) begin
        checks++; if (vif.VGA_VIDEO !== 8'(IMG_W * IMG_H - 1)) begin errors++; $display("FAIL last_pixel got=%h exp=%h", vif.VGA_VIDEO, 8'(IMG_W * IMG_H - 1)); end
      end
      if ((n - 2) % FRAME == first_pos + S * IMG_W) begin
        checks++; if ({vif.VGA_DE, vif.VGA_VIDEO} !== 9'h100) begin errors++; $display("FAIL border_pixel got=%h exp=100", {vif.VGA_DE, vif.VGA_VIDEO}); end
      end
    end
    checks++; if (hs_low !== 2 * V_TOT * H_SYNC) begin errors++; $display("FAIL hs_low_count got=%0d exp=%0d", hs_low, 2 * V_TOT * H_SYNC); end
    checks++; if (vs_low !== 2 * V_SYNC * H_TOT) begin errors++; $display("FAIL vs_low_count got=%0d exp=%0d", vs_low, 2 * V_SYNC * H_TOT); end
    checks++; if (de_cnt !== 2 * H_VIS * V_VIS) begin errors++; $display("FAIL de_count got=%0d exp=%0d", de_cnt, 2 * H_VIS * V_VIS); end
  endtask

  task automatic test_enable();
    int tgt = int'($urandom_range(Y0, V_VIS - 1)) * H_TOT + int'($urandom_range(1, H_VIS - 1));
    bit hit = 0;
    for (int i = 0; i <= FRAME && !hit; i++) begin
      if (n % FRAME == tgt) hit = 1;
      else begin
        tick();
        checks++; if (obs_vga !== exp_vga(n)) begin errors++; $display("FAIL en_pre_vga n=%0d got=%h exp=%h", n, obs_vga, exp_vga(n)); end
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL en_reach got=0 exp=1"); end
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++; if ({obs_vga, obs_bram} !== {VGA_IDLE, 15'h0}) begin errors++; $display("FAIL en_idle cyc=%0d got=%h exp=%h", i, {obs_vga, obs_bram}, {VGA_IDLE, 15'h0}); end
    end
    enable = 1'b1;
    tick();
    checks++; if (vif.FRAME_START !== 1'b0) begin errors++; $display("FAIL en_fs_early got=%b exp=0", vif.FRAME_START); end
    tick();
    checks++; if (vif.FRAME_START !== 1'b1) begin errors++; $display("FAIL en_fs_pulse got=%b exp=1", vif.FRAME_START); end
    for (int i = 0; i < FRAME / 2; i++) begin
      tick();
      checks++; if (obs_vga !== exp_vga(n)) begin errors++; $display("FAIL en_post_vga n=%0d got=%h exp=%h", n, obs_vga, exp_vga(n)); end
      checks++; if (obs_bram !== exp_bram(n)) begin errors++; $display("FAIL en_post_bram n=%0d got=%h exp=%h", n, obs_bram, exp_bram(n)); end
    end
  endtask

  task automatic test_enable_random();
    for (int r = 0; r < 4; r++) begin
      int run = int'($urandom_range(20, 400));
      int off = int'($urandom_range(1, 12));
      for (int i = 0; i < run + off; i++) begin
        enable = (i < run);
        tick();
        checks++; if (obs_vga !== exp_vga(n)) begin errors++; $display("FAIL enr_vga r=%0d n=%0d got=%h exp=%h", r, n, obs_vga, exp_vga(n)); end
        checks++; if (obs_bram !== exp_bram(n)) begin errors++; $display("FAIL enr_bram r=%0d n=%0d got=%h exp=%h", r, n, obs_bram, exp_bram(n)); end
      end
      enable = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    int tgt = int'($urandom_range(Y0, Y0 + S * IMG_H - 1)) * H_TOT
            + int'($urandom_range(X0 + 2, X0 + S * IMG_W - 1));
    int first_pos = Y0 * H_TOT + X0;
    bit hit = 0;
    for (int i = 0; i <= FRAME && !hit; i++) begin
      if (n % FRAME == tgt) hit = 1;
      else begin
        tick();
        checks++; if (obs_bram !== exp_bram(n)) begin errors++; $display("FAIL ar_pre_bram n=%0d got=%h exp=%h", n, obs_bram, exp_bram(n)); end
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL ar_reach got=0 exp=1"); end
    tick();
    tick();
    checks++; if (vif.BRAM_RE !== 1'b1) begin errors++; $display("FAIL ar_in_window got=%b exp=1", vif.BRAM_RE); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (vif.BRAM_RE !== 1'b0) begin errors++; $display("FAIL ar_re_clear got=%b exp=0", vif.BRAM_RE); end
    checks++; if (vif.VGA_VIDEO !== 8'h00) begin errors++; $display("FAIL ar_video_clear got=%h exp=00", vif.VGA_VIDEO); end
    checks++; if ({obs_vga, obs_bram} !== {VGA_IDLE, 15'h0}) begin errors++; $display("FAIL ar_all_clear got=%h exp=%h", {obs_vga, obs_bram}, {VGA_IDLE, 15'h0}); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 10; i++) begin
      tick();
      checks++; if (obs_vga !== exp_vga(n)) begin errors++; $display("FAIL ar_post_vga n=%0d got=%h exp=%h", n, obs_vga, exp_vga(n)); end
      checks++; if (obs_bram !== exp_bram(n)) begin errors++; $display("FAIL ar_post_bram n=%0d got=%h exp=%h", n, obs_bram, exp_bram(n)); end
      if (n - 1 == first_pos) begin
        checks++; if (obs_bram !== {1'b1, 14'd0}) begin errors++; $display("FAIL ar_first_addr got=%h exp=%h", obs_bram, {1'b1, 14'd0}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_enable();
    test_enable_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
